// File: rtl/lfsr_period_checker_if.sv
// Bundle between an LFSR stage and lfsr_period_checker.
// master: drives the state stream and start, observes the result.
// slave:  the checker itself.
interface lfsr_period_checker_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = WIDTH + 1
);
    logic             start;
    logic [WIDTH-1:0] state;
    logic             state_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic             maximal;
    logic             no_repeat;
    logic             lockup;

    modport master (
        output start, state, state_valid,
        input  busy, done, period, maximal, no_repeat, lockup
    );

    modport slave (
        input  start, state, state_valid,
        output busy, done, period, maximal, no_repeat, lockup
    );
endinterface

// File: rtl/lfsr_period_checker.sv
// LFSR period checker: captures a reference state from the sampled LFSR
// stream, counts steps until it recurs and reports the period together with
// maximal-length, no-repeat and all-zero lock-up flags.
// Optional feature macro: LFSR_LOCKUP_CHK_EN enables the all-zero reference
// detector; without it lockup is tied low.
module lfsr_period_checker #(
    parameter int WIDTH = 64,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    lfsr_period_checker_if.slave  bus
);

    // Count at which the sample is the 2^WIDTH-th after the reference.
    localparam logic [CNT_W-1:0] LIMIT_CNT = {{(CNT_W-1){1'b0}}, 1'b1} << WIDTH;
    localparam logic [CNT_W-1:0] MAX_PERIOD = LIMIT_CNT - 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RUN,
        DONE
    } fsm_t;

    fsm_t             fsm;
    fsm_t             fsm_next;
    logic [WIDTH-1:0] ref_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt;
    logic [CNT_W-1:0] period_r;
    logic             maximal_r;
    logic             no_repeat_r;
    logic             lockup_r;
    logic             zero_state;
    logic             match;
    logic             timeout;

`ifdef LFSR_LOCKUP_CHK_EN
    assign zero_state = (bus.state == '0);
`else
    assign zero_state = 1'b0;
`endif

    // Step arithmetic and sample classification for the RUN phase.
    always_comb begin
        nxt     = cnt + 1'b1;
        match   = (bus.state == ref_state);
        timeout = (nxt == LIMIT_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE and DONE.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE, DONE: begin
                if (bus.start) begin
                    fsm_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.state_valid) begin
                    fsm_next = RUN;
                end
            end
            RUN: begin
                if (bus.state_valid && (match || timeout)) begin
                    fsm_next = DONE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Reference capture, step counter and registered result flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_state   <= '0;
            cnt         <= '0;
            period_r    <= '0;
            maximal_r   <= 1'b0;
            no_repeat_r <= 1'b0;
            lockup_r    <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (bus.start) begin
                        cnt         <= '0;
                        period_r    <= '0;
                        maximal_r   <= 1'b0;
                        no_repeat_r <= 1'b0;
                        lockup_r    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (bus.state_valid) begin
                        ref_state <= bus.state;
                        cnt       <= '0;
                        lockup_r  <= zero_state;
                    end
                end
                RUN: begin
                    if (bus.state_valid) begin
                        if (match) begin
                            period_r  <= nxt;
                            maximal_r <= (nxt == MAX_PERIOD);
                        end else if (timeout) begin
                            no_repeat_r <= 1'b1;
                            period_r    <= '0;
                        end else begin
                            cnt <= nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (fsm == CAPTURE) || (fsm == RUN);
    assign bus.done      = (fsm == DONE);
    assign bus.period    = period_r;
    assign bus.maximal   = maximal_r;
    assign bus.no_repeat = no_repeat_r;
    assign bus.lockup    = lockup_r;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Testbench for lfsr_period_checker at WIDTH=4. A queue-based model records
// every sample after the reference and derives the period as the position of
// the first recurrence; outputs are compared every cycle plus literal checks.
module tb_lfsr_period_checker;
    localparam int WIDTH = 4;
    localparam int CNT_W = WIDTH + 1;

`ifdef LFSR_LOCKUP_CHK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    lfsr_period_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    lfsr_period_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for reference, 2 collecting, 3 result held
    int         phase = 0;
    logic [3:0] hist[$];
    int         exp_period = 0;
    bit         exp_max = 0;
    bit         exp_norep = 0;
    bit         exp_lock = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase = 0; hist.delete();
            exp_period = 0; exp_max = 0; exp_norep = 0; exp_lock = 0;
        end else if ((phase == 0 || phase == 3) && bus.start) begin
            phase = 1; hist.delete();
            exp_period = 0; exp_max = 0; exp_norep = 0; exp_lock = 0;
        end else if (phase == 1 && bus.state_valid) begin
            hist.push_back(bus.state);
            exp_lock = LOCK_EN && (bus.state == 4'h0);
            phase = 2;
        end else if (phase == 2 && bus.state_valid) begin
            hist.push_back(bus.state);
            if (bus.state == hist[0]) begin
                exp_period = hist.size() - 1;
                exp_max = (exp_period == (1 << WIDTH) - 1);
                phase = 3;
            end else if (hist.size() - 1 == (1 << WIDTH)) begin
                exp_norep = 1; exp_period = 0;
                phase = 3;
            end
        end
    end

    // Every-cycle comparison, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        chk("busy", 64'(bus.busy), 64'(phase == 1 || phase == 2));
        chk("done", 64'(bus.done), 64'(phase == 3));
        chk("period", 64'(bus.period), 64'(exp_period));
        chk("maximal", 64'(bus.maximal), 64'(exp_max));
        chk("no_repeat", 64'(bus.no_repeat), 64'(exp_norep));
        chk("lockup", 64'(bus.lockup), 64'(exp_lock));
    end

    // ---------------- stimulus ----------------
    logic [3:0] stim[$];

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic fill_lfsr();
        logic [3:0] s = 4'h1;
        stim.delete();
        for (int i = 0; i < 15; i++) begin
            stim.push_back(s);
            s = lfsr_step(s);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        bus.state_valid = 1'b1;
        bus.state = 4'(~stim[0]);
        @(negedge clk);
        bus.start = 1'b0;
        bus.state_valid = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random 3/4
    task automatic feed(input int mode, input int start_at, input int budget, input bit expect_done);
        int idx = 0;
        bit seen = 0;
        bit v;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
            bus.start = (c == start_at);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
            bus.state_valid = v;
            if (v) begin
                bus.state = stim[idx % stim.size()];
                idx++;
            end else begin
                bus.state = 4'($urandom);
            end
        end
        if (!seen) @(negedge clk);
        bus.start = 1'b0;
        bus.state_valid = 1'b0;
        chk("finished", 64'(seen), 64'(expect_done));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.state = 4'h0;
        bus.state_valid = 1'b0;
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_period", 64'(bus.period), 64'd0);
        reset = 1'b1;

        // maximal-length stream
        fill_lfsr();
        do_start();
        feed(0, -1, 60, 1);
        chk("max_period", 64'(bus.period), 64'd15);
        chk("max_flag", 64'(bus.maximal), 64'd1);
        chk("max_norep", 64'(bus.no_repeat), 64'd0);
        chk("model_max_period", 64'(exp_period), 64'd15);

        // cycle of six
        stim = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        do_start();
        feed(0, -1, 40, 1);
        chk("cyc_period", 64'(bus.period), 64'd6);
        chk("cyc_maximal", 64'(bus.maximal), 64'd0);
        chk("model_cyc_period", 64'(exp_period), 64'd6);

        // all-zero stuck state
        stim = '{4'h0};
        do_start();
        feed(0, -1, 20, 1);
        chk("zero_period", 64'(bus.period), 64'd1);
        chk("zero_lockup", 64'(bus.lockup), 64'(LOCK_EN));

        // reference never recurs
        stim.delete();
        stim.push_back(4'h1);
        for (int r = 0; r < 3; r++)
            for (int v = 2; v <= 9; v++) stim.push_back(4'(v));
        do_start();
        feed(0, -1, 40, 1);
        chk("norep_flag", 64'(bus.no_repeat), 64'd1);
        chk("norep_period", 64'(bus.period), 64'd0);
        chk("model_norep", 64'(exp_norep), 64'd1);

        // gapped valid, start pulsed mid-run
        fill_lfsr();
        do_start();
        feed(1, 10, 80, 1);
        chk("gap_period", 64'(bus.period), 64'd15);
        chk("gap_maximal", 64'(bus.maximal), 64'd1);

        // reset mid-run, then fresh measurement
        do_start();
        feed(0, -1, 6, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_period", 64'(bus.period), 64'd0);
        reset = 1'b1;
        do_start();
        feed(0, -1, 60, 1);
        chk("fresh_period", 64'(bus.period), 64'd15);

        // randomized measurements
        for (int t = 0; t < 30; t++) begin
            int len = $urandom_range(1, 20);
            stim.delete();
            for (int i = 0; i < len; i++) stim.push_back(4'($urandom_range(0, 15)));
            do_start();
            feed(2, $urandom_range(0, 30), 300, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
